// File: rtl/proc_pkg.sv
// Shared processor constants and the register-bank sequencer state type.
// Imported by rf_clear_seq and reg_bank_rw.
package proc_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      RF_CLEAR,
      RF_RUN
   } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset zero-fill sequencer for the register bank: walks every entry once,
// then holds ready high until the next synchronous reset.
module rf_clear_seq
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W = REG_ADDR_W,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (rst) begin
         state_d   = RF_CLEAR;
         clr_cnt_d = '0;
      end else begin
         case (state_q)
            RF_CLEAR: begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_ADDR) state_d = RF_RUN;
            end
            RF_RUN:  state_d = RF_RUN;
            default: state_d = RF_CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
   end

   // ready drops in the same cycle rst is asserted, before the FSM has seen it
   assign clr_we   = (state_q == RF_CLEAR);
   assign clr_addr = clr_cnt_q;
   assign ready    = (state_q == RF_RUN) && !rst;

endmodule

// File: rtl/reg_bank_rw.sv
// General-purpose register bank: one write port, two combinational read ports,
// register 0 hardwired to zero. Optional write-to-read bypass: RF_WR_BYPASS_EN.
module reg_bank_rw
   import proc_pkg::*;
#(
   parameter int unsigned DATA_W = REG_DATA_W,
   parameter int unsigned ADDR_W = REG_ADDR_W,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] wr,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] rr1,
   input  logic [ADDR_W-1:0] rr2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   rf_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   // ready already excludes rst and CLEAR, so it alone gates user writes
   assign user_we = ready && RegWrite && (wr != ZERO_ADDR);

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = wr;
      mem_data = wd;
      if (clr_we) begin
         mem_we   = 1'b1;
         mem_addr = clr_addr;
         mem_data = '0;
      end else if (user_we) begin
         mem_we = 1'b1;
      end
   end

   // No reset on storage: contents are established by the clear sequence
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_data;
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ready && (rr1 != ZERO_ADDR)) begin
         rd1 = mem_q[rr1];
`ifdef RF_WR_BYPASS_EN
         if (user_we && (wr == rr1)) rd1 = wd;
`endif
      end
      if (ready && (rr2 != ZERO_ADDR)) begin
         rd2 = mem_q[rr2];
`ifdef RF_WR_BYPASS_EN
         if (user_we && (wr == rr2)) rd2 = wd;
`endif
      end
   end

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed self-checking bench for reg_bank_rw (both RF_WR_BYPASS_EN builds).
module tb_reg_bank_rw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  wr = '0;
   logic [31:0] wd = '0;
   logic [4:0]  rr1 = '0;
   logic [4:0]  rr2 = '0;
   logic [31:0] rd1, rd2;
   logic        ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_bank_rw #(
      .DATA_W (32),
      .ADDR_W (5),
      .DEPTH  (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .RegWrite (RegWrite),
      .wr       (wr),
      .wd       (wd),
      .rr1      (rr1),
      .rr2      (rr2),
      .rd1      (rd1),
      .rd2      (rd2),
      .ready    (ready)
   );

   // Counts negedge samples with ready low (bounded); flags any nonzero read data seen.
   task automatic count_clear(output int n, output bit nonzero);
      n = 0;
      nonzero = 1'b0;
      while (!ready && n < 60) begin
         if (rd1 !== 32'h0 || rd2 !== 32'h0) nonzero = 1'b1;
         n++;
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int n;
      bit nz;
      @(negedge clk);
      rst = 1'b1; RegWrite = 1'b0; rr1 = 5'd1; rr2 = 5'd31;
      @(negedge clk); #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%b exp=0", ready); end
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
         errors++; $display("FAIL reset_rd_in_rst got=%h/%h exp=0/0", rd1, rd2);
      end
      @(negedge clk);
      rst = 1'b0; #1;
      count_clear(n, nz);
      checks++;
      if (n !== 32) begin errors++; $display("FAIL reset_clear_len got=%0d exp=32", n); end
      checks++;
      if (nz !== 1'b0) begin errors++; $display("FAIL reset_rd_during_clear got=nonzero exp=0"); end
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", ready); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      RegWrite = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
      @(negedge clk);
      RegWrite = 1'b0; rr1 = 5'd5; rr2 = 5'd6; #1;
      checks++;
      if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_r5 got=%h exp=deadbeef", rd1); end
      checks++;
      if (rd2 !== 32'h0) begin errors++; $display("FAIL write_read_r6 got=%h exp=0", rd2); end
   endtask

   task automatic test_reg_zero();
      @(negedge clk);
      RegWrite = 1'b1; wr = 5'd0; wd = 32'h12345678; rr1 = 5'd0; rr2 = 5'd0; #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
         errors++; $display("FAIL r0_same_cycle got=%h/%h exp=0/0", rd1, rd2);
      end
      @(negedge clk);
      RegWrite = 1'b0; #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
         errors++; $display("FAIL r0_after_write got=%h/%h exp=0/0", rd1, rd2);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
`ifdef RF_WR_BYPASS_EN
      exp_same = 32'hA5A5A5A5;
`else
      exp_same = 32'h0;
`endif
      @(negedge clk);
      RegWrite = 1'b1; wr = 5'd7; wd = 32'hA5A5A5A5; rr1 = 5'd5; rr2 = 5'd7; #1;
      checks++;
      if (rd2 !== exp_same) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd2, exp_same); end
      checks++;
      if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_port got=%h exp=deadbeef", rd1); end
      @(negedge clk);
      RegWrite = 1'b0; #1;
      checks++;
      if (rd2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next_cycle got=%h exp=a5a5a5a5", rd2); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      RegWrite = 1'b1; wr = 5'd1; wd = 32'h0000000B;
      @(negedge clk);
      wr = 5'd2; wd = 32'h00000016;
      @(negedge clk);
      wr = 5'd31; wd = 32'hFFFFFFFF;
      @(negedge clk);
      wr = 5'd1; wd = 32'h01010101;
      @(negedge clk);
      RegWrite = 1'b0; rr1 = 5'd31; rr2 = 5'd31; #1;
      checks++;
      if (rd1 !== 32'hFFFFFFFF || rd2 !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL b2b_r31_both got=%h/%h exp=ffffffff/ffffffff", rd1, rd2);
      end
      rr1 = 5'd1; rr2 = 5'd2; #1;
      checks++;
      if (rd1 !== 32'h01010101) begin errors++; $display("FAIL b2b_r1_overwrite got=%h exp=01010101", rd1); end
      checks++;
      if (rd2 !== 32'h00000016) begin errors++; $display("FAIL b2b_r2 got=%h exp=00000016", rd2); end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      bit nz;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; RegWrite = 1'b1; wr = 5'd3; wd = 32'hCAFEF00D; rr1 = 5'd3; rr2 = 5'd0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; #1;
      count_clear(n, nz);
      RegWrite = 1'b0; #1;
      checks++;
      if (n !== 32) begin errors++; $display("FAIL midclr_len got=%0d exp=32", n); end
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL midclr_ready got=%b exp=1", ready); end
      checks++;
      if (rd1 !== 32'h0) begin errors++; $display("FAIL midclr_r3 got=%h exp=0", rd1); end
      @(negedge clk); #1;
      checks++;
      if (rd1 !== 32'h0) begin errors++; $display("FAIL midclr_r3_later got=%h exp=0", rd1); end
   endtask

   task automatic test_reset_in_run();
      int n;
      bit nz;
      @(negedge clk);
      RegWrite = 1'b1; wr = 5'd9; wd = 32'h00000001;
      @(negedge clk);
      RegWrite = 1'b0; rr1 = 5'd9; rr2 = 5'd31; #1;
      checks++;
      if (rd1 !== 32'h1) begin errors++; $display("FAIL run_rst_r9_before got=%h exp=1", rd1); end
      rst = 1'b1; #1;
      checks++;
      if (ready !== 1'b0 || rd1 !== 32'h0) begin
         errors++; $display("FAIL run_rst_gating got=%b/%h exp=0/0", ready, rd1);
      end
      @(negedge clk);
      rst = 1'b0; #1;
      count_clear(n, nz);
      checks++;
      if (n !== 32) begin errors++; $display("FAIL run_rst_len got=%0d exp=32", n); end
      checks++;
      if (ready !== 1'b1 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
         errors++; $display("FAIL run_rst_after got=%b/%h/%h exp=1/0/0", ready, rd1, rd2);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_reg_zero();
      test_bypass();
      test_back_to_back();
      test_reset_mid_clear();
      test_reset_in_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule
